// File: rtl/ultra_multicycle.sv
// Multi-cycle accumulator-free CPU: FETCH/DECODE/EXEC/MEM/WB/HALT over a
// single request/acknowledge memory port shared by instruction and data.
module ultra_multicycle #(
    parameter int DW       = 16,
    parameter int AW       = 8,
    parameter int RW       = 2,
    parameter int RESET_PC = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [AW-1:0] pc,
    output logic          retire,
    output logic          halted
);
    generate
        if (DW < 3 + RW + AW || DW < 3 + 3 * RW) begin : g_bad_params
            $error("ultra_multicycle: DW too narrow for opcode, register and address fields");
        end
    endgenerate

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_BEQZ  = 3'b101,
        OP_JUMP  = 3'b110,
        OP_HALT  = 3'b111
    } op_t;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] ir;
    logic [DW-1:0] regs [2**RW];
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [DW-1:0] rdv;
    logic [DW-1:0] result;

    op_t           opcode;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [AW-1:0] addr;

    assign opcode    = op_t'(ir[DW-1 -: 3]);
    assign rd        = ir[DW-4 -: RW];
    assign rs        = ir[DW-4-RW -: RW];
    assign rt        = ir[DW-4-2*RW -: RW];
    assign addr      = ir[AW-1:0];
    assign mem_wdata = rdv;

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc;
        retire     = 1'b0;
        halted     = 1'b0;
        case (state)
            FETCH: begin
                // Reset parks the FSM in FETCH; gating keeps the request low until release.
                mem_req = rst_n;
                if (mem_ack) state_next = DECODE;
            end
            DECODE: state_next = EXEC;
            EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE:      state_next = MEM;
                    OP_ADD, OP_SUB, OP_AND: state_next = WB;
                    OP_BEQZ, OP_JUMP: begin
                        retire     = 1'b1;
                        state_next = FETCH;
                    end
                    OP_HALT: begin
                        retire     = 1'b1;
                        state_next = HALT;
                    end
                endcase
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_we   = (opcode == OP_STORE);
                mem_addr = addr;
                if (mem_ack) begin
                    if (opcode == OP_STORE) begin
                        retire     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end
            end
            WB: begin
                retire     = 1'b1;
                state_next = FETCH;
            end
            HALT:    halted = 1'b1;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            pc     <= AW'(RESET_PC);
            ir     <= '0;
            opa    <= '0;
            opb    <= '0;
            rdv    <= '0;
            result <= '0;
            for (int unsigned i = 0; i < 2**RW; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        ir <= mem_rdata;
                        pc <= pc + AW'(1);
                    end
                end
                DECODE: begin
                    opa <= regs[rs];
                    opb <= regs[rt];
                    rdv <= regs[rd];
                end
                EXEC: begin
                    if (opcode == OP_ADD) begin
                        result <= opa + opb;
                    end else if (opcode == OP_SUB) begin
                        result <= opa - opb;
                    end else if (opcode == OP_AND) begin
                        result <= opa & opb;
                    end else if (opcode == OP_JUMP || (opcode == OP_BEQZ && rdv == '0)) begin
                        pc <= addr;
                    end
                end
                MEM: begin
                    if (mem_ack && opcode == OP_LOAD) result <= mem_rdata;
                end
                WB:      regs[rd] <= result;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ultra_multicycle.sv
// Directed bench for ultra_multicycle: a table of small programs run against a
// behavioural memory, plus hand-written sequences for latency, branches, wrap and reset.
module tb_ultra_multicycle;
    localparam logic [2:0] OP_LD  = 3'd0;
    localparam logic [2:0] OP_ST  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_BZ  = 3'd5;
    localparam logic [2:0] OP_J   = 3'd6;
    localparam logic [15:0] HLT   = 16'hE000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [7:0]  pc;
    logic        retire;
    logic        halted;

    always #5 clk = ~clk;

    ultra_multicycle #(.DW(16), .AW(8), .RW(2), .RESET_PC(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc(pc), .retire(retire), .halted(halted)
    );

    typedef struct packed {
        logic [7:0][15:0] prog;
        logic [3:0]       delay;
        logic [7:0]       a1;
        logic [15:0]      v1;
        logic [7:0]       a2;
        logic [15:0]      v2;
        logic [7:0]       n_retire;
        logic [7:0]       fpc;
    } vec_t;

    logic [15:0]  mem [256];
    logic [8:0]   log_q [$];
    vec_t         vecs [8];
    int unsigned  checks = 0;
    int unsigned  failures = 0;
    int unsigned  ack_delay = 0;
    int unsigned  retire_cnt = 0;
    logic         stall_en = 1'b0;
    logic [7:0]   stall_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [1:0] rt,
                                        input logic [7:0] a);
        return {op, rd, rs, rt, 7'b0} | {8'b0, a};
    endfunction

    function automatic logic [7:0][15:0] prog8(input logic [15:0] w0, input logic [15:0] w1,
                                               input logic [15:0] w2, input logic [15:0] w3,
                                               input logic [15:0] w4, input logic [15:0] w5,
                                               input logic [15:0] w6, input logic [15:0] w7);
        return {w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < log_q.size()) return 32'(log_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    // Memory responder: acks after ack_delay wait cycles, checks request hold during waits.
    initial begin : responder
        logic        busy;
        logic [7:0]  cap_addr;
        logic        cap_we;
        logic [15:0] cap_wdata;
        int unsigned cnt;
        busy = 1'b0;
        cnt = 0;
        cap_addr = '0;
        cap_we = 1'b0;
        cap_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mem_req) begin
                busy = 1'b0;
                cnt = 0;
                mem_ack = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = 0;
                    cap_addr = mem_addr;
                    cap_we = mem_we;
                    cap_wdata = mem_wdata;
                end else begin
                    check("hold_addr", 32'(mem_addr), 32'(cap_addr));
                    check("hold_we", 32'(mem_we), 32'(cap_we));
                    if (cap_we) check("hold_wdata", 32'(mem_wdata), 32'(cap_wdata));
                end
                if (cnt >= ack_delay && !(stall_en && mem_addr == stall_addr)) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    log_q.push_back({mem_we, mem_addr});
                    busy = 1'b0;
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end
        end
    end

    initial begin : retire_monitor
        forever begin
            @(negedge clk);
            #4;
            if (rst_n === 1'b1 && retire === 1'b1) retire_cnt++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        retire_cnt = 0;
        log_q.delete();
        stall_en = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[3] = 16'd2;
        mem[4] = 16'd1;
        mem[5] = 16'hA5A5;
        mem[6] = 16'd7;
        mem[7] = 16'hFFFF;
        mem[8] = 16'h5A5A;
    endtask

    task automatic load_prog(input logic [7:0][15:0] p);
        for (int i = 0; i < 8; i++) mem[10 + i] = p[i];
    endtask

    task automatic wait_halt(input string name, input int unsigned budget);
        int unsigned n;
        n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL %s: timeout halted actual=0 required=1", name);
        end
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        v = vecs[k];
        do_reset();
        init_mem();
        load_prog(v.prog);
        ack_delay = 32'(v.delay);
        release_reset();
        wait_halt($sformatf("v%0d_halt", k), 600);
        repeat (2) @(negedge clk);
        check($sformatf("v%0d_mem_a1", k), 32'(mem[v.a1]), 32'(v.v1));
        check($sformatf("v%0d_mem_a2", k), 32'(mem[v.a2]), 32'(v.v2));
        check($sformatf("v%0d_retires", k), retire_cnt, 32'(v.n_retire));
        check($sformatf("v%0d_pc", k), 32'(pc), 32'(v.fpc));
        check($sformatf("v%0d_halted_idle", k), 32'({halted, mem_req}), 32'b10);
    endtask

    initial begin : main
        logic [15:0] prog_a [8];
        int unsigned rcyc [$];
        int unsigned n;

        // R1=3 via LOAD/LOAD/ADD, stored to MEM[5]
        prog_a[0] = ins(OP_LD, 2'd1, 2'd0, 2'd0, 8'd3);
        prog_a[1] = ins(OP_LD, 2'd2, 2'd0, 2'd0, 8'd4);
        prog_a[2] = ins(OP_ADD, 2'd1, 2'd1, 2'd2, 8'd0);
        prog_a[3] = ins(OP_ST, 2'd1, 2'd0, 2'd0, 8'd5);
        vecs[0] = '{prog8(prog_a[0], prog_a[1], prog_a[2], prog_a[3], HLT, HLT, HLT, HLT),
                    4'd0, 8'd5, 16'd3, 8'd8, 16'h5A5A, 8'd5, 8'd15};
        vecs[1] = '{prog8(prog_a[0], prog_a[1], prog_a[2], prog_a[3], HLT, HLT, HLT, HLT),
                    4'd3, 8'd5, 16'd3, 8'd8, 16'h5A5A, 8'd5, 8'd15};
        vecs[2] = '{prog8(ins(OP_LD, 2'd2, 2'd0, 2'd0, 8'd4), ins(OP_SUB, 2'd3, 2'd1, 2'd2, 8'd0),
                          ins(OP_AND, 2'd0, 2'd3, 2'd2, 8'd0), ins(OP_ST, 2'd3, 2'd0, 2'd0, 8'd5),
                          ins(OP_ST, 2'd0, 2'd0, 2'd0, 8'd8), HLT, HLT, HLT),
                    4'd0, 8'd5, 16'hFFFF, 8'd8, 16'd1, 8'd6, 8'd16};
        vecs[3] = '{prog8(ins(OP_BZ, 2'd1, 2'd0, 2'd0, 8'd14), ins(OP_LD, 2'd2, 2'd0, 2'd0, 8'd6),
                          ins(OP_ST, 2'd2, 2'd0, 2'd0, 8'd5), HLT,
                          ins(OP_LD, 2'd3, 2'd0, 2'd0, 8'd4), ins(OP_ST, 2'd3, 2'd0, 2'd0, 8'd5),
                          HLT, HLT),
                    4'd0, 8'd5, 16'd1, 8'd8, 16'h5A5A, 8'd4, 8'd17};
        vecs[4] = '{prog8(ins(OP_LD, 2'd1, 2'd0, 2'd0, 8'd6), ins(OP_BZ, 2'd1, 2'd0, 2'd0, 8'd14),
                          ins(OP_ST, 2'd1, 2'd0, 2'd0, 8'd5), HLT,
                          ins(OP_LD, 2'd3, 2'd0, 2'd0, 8'd4), ins(OP_ST, 2'd3, 2'd0, 2'd0, 8'd8),
                          HLT, HLT),
                    4'd0, 8'd5, 16'd7, 8'd8, 16'h5A5A, 8'd4, 8'd14};
        vecs[5] = '{prog8(ins(OP_J, 2'd0, 2'd0, 2'd0, 8'd14), ins(OP_LD, 2'd2, 2'd0, 2'd0, 8'd4),
                          ins(OP_ST, 2'd2, 2'd0, 2'd0, 8'd5), HLT,
                          ins(OP_LD, 2'd1, 2'd0, 2'd0, 8'd3), ins(OP_ST, 2'd1, 2'd0, 2'd0, 8'd8),
                          HLT, HLT),
                    4'd1, 8'd5, 16'hA5A5, 8'd8, 16'd2, 8'd4, 8'd17};
        prog_a[0] = ins(OP_LD, 2'd1, 2'd0, 2'd0, 8'd7);
        prog_a[1] = ins(OP_LD, 2'd3, 2'd0, 2'd0, 8'd4);
        prog_a[2] = ins(OP_ADD, 2'd2, 2'd1, 2'd3, 8'd0);
        prog_a[3] = ins(OP_ST, 2'd2, 2'd0, 2'd0, 8'd5);
        prog_a[4] = ins(OP_ADD, 2'd0, 2'd1, 2'd1, 8'd0);
        prog_a[5] = ins(OP_ST, 2'd0, 2'd0, 2'd0, 8'd8);
        vecs[6] = '{prog8(prog_a[0], prog_a[1], prog_a[2], prog_a[3], prog_a[4], prog_a[5], HLT, HLT),
                    4'd0, 8'd5, 16'd0, 8'd8, 16'hFFFE, 8'd7, 8'd17};
        vecs[7] = '{prog8(prog_a[0], prog_a[1], prog_a[2], prog_a[3], prog_a[4], prog_a[5], HLT, HLT),
                    4'd2, 8'd5, 16'd0, 8'd8, 16'hFFFE, 8'd7, 8'd17};

        // Reset state, first request, and per-instruction zero-wait latency
        repeat (3) @(negedge clk);
        check("rst_pc", 32'(pc), 32'd10);
        check("rst_outs", 32'({mem_req, mem_we, retire, halted}), 32'b0000);
        init_mem();
        mem[10] = ins(OP_LD, 2'd1, 2'd0, 2'd0, 8'd3);
        mem[11] = ins(OP_ADD, 2'd2, 2'd1, 2'd1, 8'd0);
        mem[12] = ins(OP_ST, 2'd2, 2'd0, 2'd0, 8'd5);
        mem[13] = HLT;
        ack_delay = 0;
        release_reset();
        #1;
        check("first_req", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b0, 8'd10}));
        for (int unsigned cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clk);
            #4;
            if (retire === 1'b1) rcyc.push_back(cyc);
        end
        check("lat_count", rcyc.size(), 32'd4);
        check("lat_load", rcyc.size() > 0 ? rcyc[0] : 0, 32'd5);
        check("lat_alu", rcyc.size() > 1 ? rcyc[1] : 0, 32'd9);
        check("lat_store", rcyc.size() > 2 ? rcyc[2] : 0, 32'd13);
        check("lat_halt", rcyc.size() > 3 ? rcyc[3] : 0, 32'd16);
        check("lat_mem5", 32'(mem[5]), 32'd4);
        check("lat_halted", 32'(halted), 32'd1);

        for (int k = 0; k < 8; k++) run_vec(k);

        // BEQZ to 20: taken with R0=0, not taken with R1=7
        do_reset();
        init_mem();
        mem[10] = ins(OP_BZ, 2'd0, 2'd0, 2'd0, 8'd20);
        mem[11] = HLT;
        mem[20] = HLT;
        ack_delay = 0;
        release_reset();
        wait_halt("bz_taken_halt", 100);
        check("bz_taken_len", log_q.size(), 32'd2);
        check("bz_taken_f0", log_at(0), 32'd10);
        check("bz_taken_f1", log_at(1), 32'd20);
        check("bz_taken_pc", 32'(pc), 32'd21);

        do_reset();
        init_mem();
        mem[10] = ins(OP_LD, 2'd1, 2'd0, 2'd0, 8'd6);
        mem[11] = ins(OP_BZ, 2'd1, 2'd0, 2'd0, 8'd20);
        mem[12] = HLT;
        mem[20] = HLT;
        release_reset();
        wait_halt("bz_not_halt", 100);
        check("bz_not_len", log_q.size(), 32'd4);
        check("bz_not_f2", log_at(2), 32'd11);
        check("bz_not_f3", log_at(3), 32'd12);

        // JUMP 255 then pc wraps to 0
        do_reset();
        init_mem();
        mem[10] = ins(OP_J, 2'd0, 2'd0, 2'd0, 8'd255);
        mem[255] = ins(OP_ADD, 2'd1, 2'd1, 2'd1, 8'd0);
        mem[0] = HLT;
        release_reset();
        n = 0;
        while (!(mem_req === 1'b1 && mem_addr == 8'd255) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wrap_reach255", 32'(mem_addr), 32'd255);
        @(negedge clk);
        check("wrap_pc0", 32'(pc), 32'd0);
        wait_halt("wrap_halt", 100);
        check("wrap_len", log_q.size(), 32'd3);
        check("wrap_f2", log_at(2), 32'd0);
        check("wrap_pc_end", 32'(pc), 32'd1);

        // Reset while a LOAD is stalled in MEM
        do_reset();
        init_mem();
        mem[10] = ins(OP_LD, 2'd1, 2'd0, 2'd0, 8'd3);
        mem[11] = HLT;
        stall_en = 1'b1;
        stall_addr = 8'd3;
        release_reset();
        n = 0;
        while (!(mem_req === 1'b1 && mem_addr == 8'd3) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_mem", 32'(mem_addr), 32'd3);
        repeat (3) @(negedge clk);
        check("abort_pre_retires", retire_cnt, 32'd0);
        check("abort_pre_pc", 32'(pc), 32'd11);
        #2 rst_n = 1'b0;
        #1;
        check("abort_async", 32'({pc, mem_req, retire, halted}), 32'({8'd10, 3'b000}));
        repeat (2) @(negedge clk);
        stall_en = 1'b0;
        retire_cnt = 0;
        log_q.delete();
        mem[10] = ins(OP_ST, 2'd1, 2'd0, 2'd0, 8'd5);
        release_reset();
        wait_halt("abort_halt", 100);
        check("abort_r1_zero", 32'(mem[5]), 32'd0);
        check("abort_refetch", log_at(0), 32'd10);
        check("abort_retires", retire_cnt, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
